// File: rtl/bypass_pkg.sv
// -----------------------------------------------------------------------------
// bypass_pkg
//   Shared types and helpers for the Beta operand-forwarding network.
//   - ZERO_REG_DEF : default index of the hard-wired zero register
//   - RC_W         : storage width of a scoreboard destination field; the
//                    network zero-extends its REG_AW-bit addresses into it, so
//                    any REG_AW up to RC_W is supported by the same entry type
//   - sb_entry_t   : one scoreboard entry {valid, rc, load, sel_pc}
//   - onehot0()    : true when at most one bit of the vector is set
// -----------------------------------------------------------------------------
package bypass_pkg;

   localparam int ZERO_REG_DEF = 31;
   localparam int RC_W         = 8;

   typedef struct packed {
      logic            valid;
      logic [RC_W-1:0] rc;
      logic            load;
      logic            sel_pc;
   } sb_entry_t;

   function automatic logic onehot0(input logic [31:0] v);
      return (v & (v - 32'd1)) == 32'd0;
   endfunction

endpackage

// File: rtl/bypass_port_mux.sv
// -----------------------------------------------------------------------------
// bypass_port_mux
//   Combinational priority select for one operand read port.
//   Ports:
//     sb          in  scoreboard, entry 0 = EX (youngest) .. NUM_STAGES-1 = WB
//     ra          in  read address
//     rf_data     in  register-file read data for this port
//     stage_y     in  Y/result value per stage
//     stage_pc    in  PC+4 value per stage
//     operand     out forwarded operand (0 for the zero register)
//     hit_stage   out one-hot source stage, zero when served by RF / zero reg
//     load_hazard out selected stage holds a load whose data is not ready yet
// -----------------------------------------------------------------------------
module bypass_port_mux
   import bypass_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter int REG_AW           = 5,
   parameter int ZERO_REG         = ZERO_REG_DEF,
   parameter int NUM_STAGES       = 3,
   parameter int LOAD_READY_STAGE = 2
) (
   input  sb_entry_t                   sb [NUM_STAGES],
   input  logic [REG_AW-1:0]           ra,
   input  logic [XLEN-1:0]             rf_data,
   input  logic [NUM_STAGES*XLEN-1:0]  stage_y,
   input  logic [NUM_STAGES*XLEN-1:0]  stage_pc,
   output logic [XLEN-1:0]             operand,
   output logic [NUM_STAGES-1:0]       hit_stage,
   output logic                        load_hazard
);

   logic found;

   // NOTE: every output gets a default before any branch, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      operand     = rf_data;
      hit_stage   = '0;
      load_hazard = 1'b0;
      found       = 1'b0;
      if (ra == REG_AW'(ZERO_REG)) begin
         operand = '0;
      end else begin
         // Ascending scan with a found flag: the youngest matching stage wins.
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (!found && sb[k].valid && sb[k].rc == RC_W'(ra)) begin
               found        = 1'b1;
               hit_stage[k] = 1'b1;
               // WB already carries the final write-back value on stage_y.
               if (k == NUM_STAGES - 1 || !sb[k].sel_pc)
                  operand = stage_y[k*XLEN +: XLEN];
               else
                  operand = stage_pc[k*XLEN +: XLEN];
               load_hazard = sb[k].load && (k < LOAD_READY_STAGE);
            end
         end
      end
   end

endmodule

// File: rtl/bypass_network.sv
// -----------------------------------------------------------------------------
// bypass_network
//   Operand-forwarding and load-use hazard unit between RF and EX of the Beta
//   pipeline. Keeps a per-stage destination scoreboard and forwards stage data
//   to NUM_RD_PORTS read ports; requests a stall on load-use hazards.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     hold            global freeze of the scoreboard
//     issue_*         RF-stage instruction: valid, rc, writes rc, load, sel_pc
//     ra, rf_data     packed per-port read addresses and RF read data
//     stage_y/pc      packed per-stage result and PC+4 values
//     operand         packed per-port forwarded operands
//     stall           load-use hazard on any port
//     hit_stage       packed per-port one-hot source stage
//   Optional (macro BYPASS_PERF_EN): perf_stall_cnt, perf_fwd_cnt saturating
//   performance counters.
// -----------------------------------------------------------------------------
module bypass_network
   import bypass_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter int REG_AW           = 5,
   parameter int ZERO_REG         = ZERO_REG_DEF,
   parameter int NUM_RD_PORTS     = 2,
   parameter int NUM_STAGES       = 3,
   parameter int LOAD_READY_STAGE = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              hold,
   input  logic                              issue_valid,
   input  logic [REG_AW-1:0]                 issue_rc,
   input  logic                              issue_wr,
   input  logic                              issue_load,
   input  logic                              issue_sel_pc,
   input  logic [NUM_RD_PORTS*REG_AW-1:0]    ra,
   input  logic [NUM_RD_PORTS*XLEN-1:0]      rf_data,
   input  logic [NUM_STAGES*XLEN-1:0]        stage_y,
   input  logic [NUM_STAGES*XLEN-1:0]        stage_pc,
   output logic [NUM_RD_PORTS*XLEN-1:0]      operand,
   output logic                              stall,
   output logic [NUM_RD_PORTS*NUM_STAGES-1:0] hit_stage
`ifdef BYPASS_PERF_EN
   ,
   output logic [31:0]                       perf_stall_cnt,
   output logic [31:0]                       perf_fwd_cnt
`endif
);

   sb_entry_t                 sb [NUM_STAGES];
   sb_entry_t                 new_entry;
   logic [NUM_RD_PORTS-1:0]   load_hazard;

   // ---------------------------------------------------------------- ports
   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      bypass_port_mux #(
         .XLEN             (XLEN),
         .REG_AW           (REG_AW),
         .ZERO_REG         (ZERO_REG),
         .NUM_STAGES       (NUM_STAGES),
         .LOAD_READY_STAGE (LOAD_READY_STAGE)
      ) u_mux (
         .sb          (sb),
         .ra          (ra[p*REG_AW +: REG_AW]),
         .rf_data     (rf_data[p*XLEN +: XLEN]),
         .stage_y     (stage_y),
         .stage_pc    (stage_pc),
         .operand     (operand[p*XLEN +: XLEN]),
         .hit_stage   (hit_stage[p*NUM_STAGES +: NUM_STAGES]),
         .load_hazard (load_hazard[p])
      );
   end

   assign stall = |load_hazard;

   // ----------------------------------------------------------- scoreboard
   // A stalled RF instruction enters EX as a bubble; writes to the zero
   // register are never tracked so they can never be forwarded.
   always_comb begin
      new_entry.valid  = issue_valid && issue_wr && !stall &&
                         (issue_rc != REG_AW'(ZERO_REG));
      new_entry.rc     = RC_W'(issue_rc);
      new_entry.load   = issue_load;
      new_entry.sel_pc = issue_sel_pc;
   end

   // NOTE: the scoreboard is a small shift register, not a RAM, so every
   // entry is reset; a stale valid bit after reset would forward garbage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_STAGES; k++)
            sb[k] <= '0;
      end else if (!hold) begin
         // NOTE: non-blocking assignments let every entry shift from the old
         // value of its neighbour regardless of statement order.
         sb[0] <= new_entry;
         for (int k = 1; k < NUM_STAGES; k++)
            sb[k] <= sb[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < NUM_RD_PORTS; p++)
            assert (onehot0(32'(hit_stage[p*NUM_STAGES +: NUM_STAGES])));
      end
   end

`ifdef BYPASS_PERF_EN
   // ------------------------------------------------------ perf counters
   localparam int FWD_W = $clog2(NUM_RD_PORTS + 1);

   logic [FWD_W-1:0] fwd_ports;
   logic [32:0]      stall_sum;
   logic [32:0]      fwd_sum;

   always_comb begin
      fwd_ports = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++)
         fwd_ports = fwd_ports + FWD_W'(|hit_stage[p*NUM_STAGES +: NUM_STAGES]);
      // One extra bit catches the carry so both counters saturate at all-ones.
      stall_sum = {1'b0, perf_stall_cnt} + 33'd1;
      fwd_sum   = {1'b0, perf_fwd_cnt} + 33'(fwd_ports);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else if (!hold) begin
         if (stall)
            perf_stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
         if (issue_valid)
            perf_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_bypass_network.sv
// -----------------------------------------------------------------------------
// tb_bypass_network
//   Directed bench for bypass_network with default parameters (2 ports,
//   3 stages, load data ready at stage 2). Expected values are queued as each
//   step is driven and popped/compared once the combinational outputs settle.
// -----------------------------------------------------------------------------
module tb_bypass_network;

   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NP   = 2;
   localparam int NS   = 3;

   localparam int K_OP    = 0;
   localparam int K_HIT   = 1;
   localparam int K_STALL = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 hold;
   logic                 issue_valid;
   logic [AW-1:0]        issue_rc;
   logic                 issue_wr;
   logic                 issue_load;
   logic                 issue_sel_pc;
   logic [NP*AW-1:0]     ra;
   logic [NP*XLEN-1:0]   rf_data;
   logic [NS*XLEN-1:0]   stage_y;
   logic [NS*XLEN-1:0]   stage_pc;
   logic [NP*XLEN-1:0]   operand;
   logic                 stall;
   logic [NP*NS-1:0]     hit_stage;
`ifdef BYPASS_PERF_EN
   logic [31:0]          perf_stall_cnt;
   logic [31:0]          perf_fwd_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      int          kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   bypass_network dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hold         (hold),
      .issue_valid  (issue_valid),
      .issue_rc     (issue_rc),
      .issue_wr     (issue_wr),
      .issue_load   (issue_load),
      .issue_sel_pc (issue_sel_pc),
      .ra           (ra),
      .rf_data      (rf_data),
      .stage_y      (stage_y),
      .stage_pc     (stage_pc),
      .operand      (operand),
      .stall        (stall),
      .hit_stage    (hit_stage)
`ifdef BYPASS_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_fwd_cnt   (perf_fwd_cnt)
`endif
   );

   // ------------------------------------------------------------ helpers
   task automatic push(input string tag, input int kind, input int port,
                       input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.port = port;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic exp_op(input string tag, input int port, input logic [31:0] val);
      push(tag, K_OP, port, val);
   endtask

   task automatic exp_hit(input string tag, input int port, input logic [NS-1:0] val);
      push(tag, K_HIT, port, 32'(val));
   endtask

   task automatic exp_stall(input string tag, input logic val);
      push(tag, K_STALL, 0, 32'(val));
   endtask

   // Let the combinational outputs settle, then compare everything queued.
   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_OP:    obs = operand[e.port*XLEN +: XLEN];
            K_HIT:   obs = 32'(hit_stage[e.port*NS +: NS]);
            default: obs = 32'(stall);
         endcase
         n_cmp++;
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   // Advance to just after the next rising edge; inputs change only here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [AW-1:0] rc, input logic wr,
                        input logic ld, input logic spc);
      issue_valid  = v;
      issue_rc     = rc;
      issue_wr     = wr;
      issue_load   = ld;
      issue_sel_pc = spc;
   endtask

   task automatic no_issue();
      issue(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic set_ra(input int p, input logic [AW-1:0] a);
      ra[p*AW +: AW] = a;
   endtask

   task automatic set_y(input int k, input logic [31:0] v);
      stage_y[k*XLEN +: XLEN] = v;
   endtask

   task automatic set_pc(input int k, input logic [31:0] v);
      stage_pc[k*XLEN +: XLEN] = v;
   endtask

   // Drain the pipeline with bubbles while both ports read untracked regs.
   task automatic flush();
      no_issue();
      set_ra(0, 5'd3);
      set_ra(1, 5'd0);
      repeat (NS) tick();
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      rst_n    = 1'b0;
      hold     = 1'b0;
      no_issue();
      ra       = '0;
      rf_data  = '0;
      stage_y  = '0;
      stage_pc = '0;
      set_ra(0, 5'd3);
      set_ra(1, 5'd0);
      rf_data[0*XLEN +: XLEN] = 32'h11;
      rf_data[1*XLEN +: XLEN] = 32'h22;
      for (int k = 0; k < NS; k++) begin
         set_y(k, 32'h1000 + 32'(k));
         set_pc(k, 32'h2000 + 32'(k));
      end

      // Reset: everything comes from the register file.
      #2;
      exp_op("rst_op0", 0, 32'h11);
      exp_op("rst_op1", 1, 32'h22);
      exp_hit("rst_hit0", 0, 3'b000);
      exp_hit("rst_hit1", 1, 3'b000);
      exp_stall("rst_stall", 1'b0);
`ifdef BYPASS_PERF_EN
      push("rst_perf_stall", K_STALL, 0, 32'(perf_stall_cnt != 0 ? 1 : 0));
`endif
      check();
      tick();
      rst_n = 1'b1;

      // EX forward: ADD r4 issued, consumer reads r4 next cycle.
      issue(1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      no_issue();
      set_ra(0, 5'd4);
      set_y(0, 32'hAB);
      exp_op("ex_fwd_op0", 0, 32'hAB);
      exp_hit("ex_fwd_hit0", 0, 3'b001);
      exp_stall("ex_fwd_stall", 1'b0);
      check();

      // PC forward: JMP r5 reaches MEM two cycles after issue; r4 is in WB.
      issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
      tick();
      no_issue();
      tick();
      set_ra(1, 5'd5);
      set_pc(1, 32'h104);
      set_y(1, 32'hDEAD);
      set_y(2, 32'h5555);
      exp_op("pc_fwd_op1", 1, 32'h104);
      exp_hit("pc_fwd_hit1", 1, 3'b010);
      exp_op("wb_fwd_op0", 0, 32'h5555);
      exp_hit("wb_fwd_hit0", 0, 3'b100);
      exp_stall("pc_fwd_stall", 1'b0);
      check();

      flush();
      exp_hit("flush_hit0", 0, 3'b000);
      exp_op("flush_op0", 0, 32'h11);
      check();

      // Load-use: LD r7, then a consumer of r7 stalls two cycles.
      issue(1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      set_ra(0, 5'd7);
      set_y(2, 32'h7777);
      exp_stall("ld_use_c1_stall", 1'b1);
      exp_hit("ld_use_c1_hit0", 0, 3'b001);
      check();
      tick();
      exp_stall("ld_use_c2_stall", 1'b1);
      exp_hit("ld_use_c2_hit0", 0, 3'b010);
      check();
      tick();
      exp_stall("ld_use_c3_stall", 1'b0);
      exp_hit("ld_use_c3_hit0", 0, 3'b100);
      exp_op("ld_use_c3_op0", 0, 32'h7777);
      check();
      // The consumer now enters EX; the bubbles must not have tracked r8.
      tick();
      no_issue();
      set_ra(1, 5'd8);
      set_y(0, 32'h8888);
      exp_hit("ld_use_r8_hit1", 1, 3'b001);
      exp_op("ld_use_r8_op1", 1, 32'h8888);
      check();

      flush();

      // Priority / zero register: r9 in EX and WB, r31 write never tracked.
      issue(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, 5'd31, 1'b1, 1'b1, 1'b0);
      tick();
      issue(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      tick();
      no_issue();
      set_ra(0, 5'd9);
      set_ra(1, 5'd31);
      rf_data[1*XLEN +: XLEN] = 32'h31;
      set_y(0, 32'h900);
      set_y(2, 32'h902);
      exp_op("prio_op0", 0, 32'h900);
      exp_hit("prio_hit0", 0, 3'b001);
      exp_op("zero_op1", 1, 32'h0);
      exp_hit("zero_hit1", 1, 3'b000);
      exp_stall("zero_stall", 1'b0);
      check();
      rf_data[1*XLEN +: XLEN] = 32'h22;

      flush();

      // Hold: load r2 frozen in EX keeps the stall up for three cycles.
      issue(1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
      tick();
      no_issue();
      set_ra(0, 5'd2);
      set_y(2, 32'h2222);
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         exp_stall($sformatf("hold_c%0d_stall", c), 1'b1);
         exp_hit($sformatf("hold_c%0d_hit0", c), 0, 3'b001);
         check();
         tick();
      end
      hold = 1'b0;
      exp_stall("hold_rel0_stall", 1'b1);
      exp_hit("hold_rel0_hit0", 0, 3'b001);
      check();
      tick();
      exp_stall("hold_rel1_stall", 1'b1);
      exp_hit("hold_rel1_hit0", 0, 3'b010);
      check();
      tick();
      exp_stall("hold_rel2_stall", 1'b0);
      exp_hit("hold_rel2_hit0", 0, 3'b100);
      exp_op("hold_rel2_op0", 0, 32'h2222);
      check();
      tick();
      rf_data[0*XLEN +: XLEN] = 32'h55;
      exp_hit("hold_gone_hit0", 0, 3'b000);
      exp_op("hold_gone_op0", 0, 32'h55);
      check();

      // Reset mid-operation: r10 in EX is dropped immediately.
      issue(1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      tick();
      no_issue();
      set_ra(0, 5'd10);
      set_y(0, 32'hA0A0);
      exp_hit("mid_pre_hit0", 0, 3'b001);
      exp_op("mid_pre_op0", 0, 32'hA0A0);
      check();
      rst_n = 1'b0;
      exp_hit("mid_rst_hit0", 0, 3'b000);
      exp_op("mid_rst_op0", 0, 32'h55);
      check();
      tick();
      rst_n = 1'b1;
      tick();
      exp_hit("mid_post_hit0", 0, 3'b000);
      exp_stall("mid_post_stall", 1'b0);
      check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
